// File: rtl/dm_arbiter.sv
// Two-port arbiter for the single-port data-memory block RAM: round-robin grant,
// byte-lane write enables, lane-replicated store data and formatted load results.
module dm_arbiter #(
  parameter int AW         = 15,
  parameter bit RESET_LAST = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [1:0]    m0_size,
  input  logic          m0_sext,
  input  logic [AW-1:0] m0_addr,
  input  logic [31:0]   m0_wdata,
  output logic          m0_ready,
  output logic [31:0]   m0_rdata,
  output logic          m0_err,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [1:0]    m1_size,
  input  logic          m1_sext,
  input  logic [AW-1:0] m1_addr,
  input  logic [31:0]   m1_wdata,
  output logic          m1_ready,
  output logic [31:0]   m1_rdata,
  output logic          m1_err,
  output logic [3:0]    ram_wea,
  output logic [AW-3:0] ram_addr,
  output logic [31:0]   ram_din,
  input  logic [31:0]   ram_dout,
  output logic          busy,
  output logic          gnt_id
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          gnt_q, gnt_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic          sext_q, sext_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic          m0_err_q, m0_err_d, m1_err_q, m1_err_d;

  logic          pick;
  logic          err_c;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [31:0]   load_fmt;
  logic [3:0]    be;

  // On a tie the port that was not served last wins.
  assign pick  = (m0_req && m1_req) ? ~last_q : m1_req;

  assign err_c = (size_q == 2'd3) ||
                 (size_q == 2'd1 && addr_q[0]) ||
                 (size_q == 2'd2 && addr_q[1:0] != 2'b00);

  always_comb begin
    lane_b = ram_dout[7:0];
    case (addr_q[1:0])
      2'd1:    lane_b = ram_dout[15:8];
      2'd2:    lane_b = ram_dout[23:16];
      2'd3:    lane_b = ram_dout[31:24];
      default: lane_b = ram_dout[7:0];
    endcase
    lane_h = addr_q[1] ? ram_dout[31:16] : ram_dout[15:0];
    case (size_q)
      2'd0:    load_fmt = {{24{sext_q & lane_b[7]}}, lane_b};
      2'd1:    load_fmt = {{16{sext_q & lane_h[15]}}, lane_h};
      default: load_fmt = ram_dout;
    endcase
  end

  always_comb begin
    case (size_q)
      2'd0:    be = 4'b0001 << addr_q[1:0];
      2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
      2'd2:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    case (size_q)
      2'd0:    ram_din = {4{wdata_q[7:0]}};
      2'd1:    ram_din = {2{wdata_q[15:0]}};
      default: ram_din = wdata_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    size_d     = size_q;
    sext_d     = sext_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    m0_err_d   = m0_err_q;
    m1_err_d   = m1_err_q;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          gnt_d   = pick;
          last_d  = pick;
          we_d    = pick ? m1_we    : m0_we;
          size_d  = pick ? m1_size  : m0_size;
          sext_d  = pick ? m1_sext  : m0_sext;
          addr_d  = pick ? m1_addr  : m0_addr;
          wdata_d = pick ? m1_wdata : m0_wdata;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (gnt_q) m1_err_d = err_c;
        else       m0_err_d = err_c;
        if (err_c) begin
          if (gnt_q) m1_rdata_d = '0;
          else       m0_rdata_d = '0;
          state_d = RESP;
        end else begin
          state_d = we_q ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (gnt_q) m1_rdata_d = load_fmt;
        else       m0_rdata_d = load_fmt;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      last_q     <= RESET_LAST;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      size_q     <= '0;
      sext_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      m0_err_q   <= 1'b0;
      m1_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      size_q     <= size_d;
      sext_q     <= sext_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      m0_err_q   <= m0_err_d;
      m1_err_q   <= m1_err_d;
    end
  end

  // RAM-side outputs decode from the state flop so reset clears them asynchronously.
  assign ram_wea  = (state_q == ACCESS && we_q && !err_c) ? be : '0;
  assign ram_addr = addr_q[AW-1:2];
  assign busy     = (state_q != IDLE);
  assign gnt_id   = gnt_q;
  assign m0_ready = (state_q == RESP) && !gnt_q;
  assign m1_ready = (state_q == RESP) && gnt_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;
  assign m0_err   = m0_err_q;
  assign m1_err   = m1_err_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: vector table of single transactions plus
// reset-in-WAIT and contention sequences against a 1-cycle-latency RAM model.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 0, m0_we = 0, m0_sext = 0;
  logic [1:0]  m0_size = 0;
  logic [14:0] m0_addr = 0;
  logic [31:0] m0_wdata = 0;
  logic        m1_req = 0, m1_we = 0, m1_sext = 0;
  logic [1:0]  m1_size = 0;
  logic [14:0] m1_addr = 0;
  logic [31:0] m1_wdata = 0;
  logic        m0_ready, m0_err, m1_ready, m1_err, busy, gnt_id;
  logic [31:0] m0_rdata, m1_rdata, ram_din;
  logic [31:0] ram_dout = 0;
  logic [3:0]  ram_wea;
  logic [12:0] ram_addr;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [0:8191];

  dm_arbiter #(.AW(15), .RESET_LAST(1'b1)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_sext(m0_sext),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ready(m0_ready),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_sext(m1_sext),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ready(m1_ready),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .ram_wea(ram_wea), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .busy(busy), .gnt_id(gnt_id)
  );

  always #5 clk = ~clk;

  // RAM model: byte-enabled writes, registered read-first output.
  always @(posedge clk) begin
    if (!reset) begin
      mem[8] <= 32'hCAFEBABE;
    end else begin
      for (int b = 0; b < 4; b++)
        if (ram_wea[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
    end
    ram_dout <= mem[ram_addr];
  end

  typedef struct {
    logic        port;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [14:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wea;
    logic [12:0] raddr;
    logic [31:0] din;
    logic [31:0] rdata;
    logic        chk_rd;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_port(input logic p, input logic req, input vec_t v);
    if (p) begin
      m1_req = req; m1_we = v.we; m1_size = v.size; m1_sext = v.sext;
      m1_addr = v.addr; m1_wdata = v.wdata;
    end else begin
      m0_req = req; m0_we = v.we; m0_size = v.size; m0_sext = v.sext;
      m0_addr = v.addr; m0_wdata = v.wdata;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          cyc;
    logic        seen, other;
    logic [3:0]  wea_s;
    logic [12:0] a_s;
    logic [31:0] din_s, rd_s;
    logic        err_s, rdy_after;
    @(negedge clk);
    set_port(v.port, 1'b1, v);
    cyc = 0; seen = 0; other = 0;
    wea_s = 'x; a_s = 'x; din_s = 'x; rd_s = 'x; err_s = 1'bx;
    while (!seen && cyc < 20) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 1) begin
        wea_s = ram_wea; a_s = ram_addr; din_s = ram_din;
      end
      if (v.port ? m0_ready : m1_ready) other = 1'b1;
      if (v.port ? m1_ready : m0_ready) begin
        seen  = 1'b1;
        rd_s  = v.port ? m1_rdata : m0_rdata;
        err_s = v.port ? m1_err : m0_err;
        set_port(v.port, 1'b0, v);
      end
    end
    if (!seen) begin
      set_port(v.port, 1'b0, v);
      n_cmp++; n_bad++;
      $display("FAIL v%0d_timeout: got no ready within 20 cycles expected ready", idx);
    end else begin
      chk($sformatf("v%0d_lat", idx), cyc, v.lat);
      chk($sformatf("v%0d_wea", idx), {28'd0, wea_s}, {28'd0, v.wea});
      chk($sformatf("v%0d_ram_addr", idx), {19'd0, a_s}, {19'd0, v.raddr});
      chk($sformatf("v%0d_ram_din", idx), din_s, v.din);
      chk($sformatf("v%0d_err", idx), {31'd0, err_s}, {31'd0, v.err});
      if (v.chk_rd) chk($sformatf("v%0d_rdata", idx), rd_s, v.rdata);
      chk($sformatf("v%0d_other_ready", idx), {31'd0, other}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rdy_after = v.port ? m1_ready : m0_ready;
      chk($sformatf("v%0d_one_pulse", idx), {31'd0, rdy_after}, 32'd0);
    end
  endtask

  initial begin
    vec_t nv;
    int   k, cyc;
    logic exp_p;

    //          port  we    sz    sx    addr      wdata          wea   raddr  din            rdata          chkrd err  lat
    vecs[0]  = '{1'b0, 1'b1, 2'd2, 1'b0, 15'h0010, 32'hDEADBEEF, 4'hF, 13'd4,  32'hDEADBEEF, 32'h0,         1'b0, 1'b0, 2};
    vecs[1]  = '{1'b0, 1'b1, 2'd0, 1'b0, 15'h0013, 32'h0000005A, 4'h8, 13'd4,  32'h5A5A5A5A, 32'h0,         1'b0, 1'b0, 2};
    vecs[2]  = '{1'b0, 1'b0, 2'd0, 1'b1, 15'h0013, 32'h0,        4'h0, 13'd4,  32'h0,        32'h0000005A, 1'b1, 1'b0, 3};
    vecs[3]  = '{1'b0, 1'b1, 2'd0, 1'b0, 15'h0013, 32'h00000080, 4'h8, 13'd4,  32'h80808080, 32'h0,         1'b0, 1'b0, 2};
    vecs[4]  = '{1'b0, 1'b0, 2'd0, 1'b1, 15'h0013, 32'h0,        4'h0, 13'd4,  32'h0,        32'hFFFFFF80, 1'b1, 1'b0, 3};
    vecs[5]  = '{1'b0, 1'b0, 2'd0, 1'b0, 15'h0013, 32'h0,        4'h0, 13'd4,  32'h0,        32'h00000080, 1'b1, 1'b0, 3};
    vecs[6]  = '{1'b0, 1'b1, 2'd1, 1'b0, 15'h0022, 32'h00001234, 4'hC, 13'd8,  32'h12341234, 32'h0,         1'b0, 1'b0, 2};
    vecs[7]  = '{1'b0, 1'b0, 2'd2, 1'b1, 15'h0020, 32'h0,        4'h0, 13'd8,  32'h0,        32'h1234BABE, 1'b1, 1'b0, 3};
    vecs[8]  = '{1'b0, 1'b0, 2'd2, 1'b0, 15'h0002, 32'h0,        4'h0, 13'd0,  32'h0,        32'h0,         1'b1, 1'b1, 2};
    vecs[9]  = '{1'b0, 1'b1, 2'd3, 1'b0, 15'h0040, 32'h0,        4'h0, 13'd16, 32'h0,        32'h0,         1'b1, 1'b1, 2};
    vecs[10] = '{1'b1, 1'b0, 2'd1, 1'b1, 15'h0012, 32'h0,        4'h0, 13'd4,  32'h0,        32'hFFFF80AD, 1'b1, 1'b0, 3};
    vecs[11] = '{1'b1, 1'b1, 2'd1, 1'b0, 15'h0021, 32'h0000AAAA, 4'h0, 13'd8,  32'hAAAAAAAA, 32'h0,         1'b1, 1'b1, 2};
    vecs[12] = '{1'b1, 1'b0, 2'd1, 1'b0, 15'h0010, 32'h0,        4'h0, 13'd4,  32'h0,        32'h0000BEEF, 1'b1, 1'b0, 3};
    vecs[13] = '{1'b0, 1'b0, 2'd0, 1'b1, 15'h0011, 32'h0,        4'h0, 13'd4,  32'h0,        32'hFFFFFFBE, 1'b1, 1'b0, 3};
    vecs[14] = '{1'b0, 1'b1, 2'd0, 1'b0, 15'h0031, 32'h00000077, 4'h2, 13'd12, 32'h77777777, 32'h0,         1'b0, 1'b0, 2};
    vecs[15] = '{1'b1, 1'b0, 2'd0, 1'b1, 15'h0031, 32'h0,        4'h0, 13'd12, 32'h0,        32'h00000077, 1'b1, 1'b0, 3};

    #1 reset = 1'b0;
    #3;
    chk("rst_m0_ready", {31'd0, m0_ready}, 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_m0_err",   {31'd0, m0_err}, 32'd0);
    chk("rst_m1_ready", {31'd0, m1_ready}, 32'd0);
    chk("rst_m1_rdata", m1_rdata, 32'd0);
    chk("rst_m1_err",   {31'd0, m1_err}, 32'd0);
    chk("rst_ram_wea",  {28'd0, ram_wea}, 32'd0);
    chk("rst_ram_addr", {19'd0, ram_addr}, 32'd0);
    chk("rst_ram_din",  ram_din, 32'd0);
    chk("rst_busy",     {31'd0, busy}, 32'd0);
    chk("rst_gnt_id",   {31'd0, gnt_id}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;

    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    // Reset while an m1 load sits in WAIT: transaction is dropped silently.
    nv = vecs[15];
    nv.addr = 15'h0010; nv.size = 2'd2;
    @(negedge clk);
    set_port(1'b1, 1'b1, nv);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("wait_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b0;
    set_port(1'b1, 1'b0, nv);
    #1;
    chk("midrst_busy",     {31'd0, busy}, 32'd0);
    chk("midrst_wea",      {28'd0, ram_wea}, 32'd0);
    chk("midrst_m1_ready", {31'd0, m1_ready}, 32'd0);
    chk("midrst_m1_rdata", m1_rdata, 32'd0);
    k = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (m0_ready || m1_ready) k++;
    end
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (m0_ready || m1_ready) k++;
    end
    chk("midrst_no_ready", k, 0);

    // Continuous contention after reset: grants must alternate starting with port 0.
    nv = vecs[0];
    nv.addr = 15'h0050; nv.wdata = 32'h11111111;
    set_port(1'b0, 1'b1, nv);
    nv.addr = 15'h0054; nv.wdata = 32'h22222222;
    set_port(1'b1, 1'b1, nv);
    k = 0; cyc = 0;
    while (k < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (m0_ready && m1_ready) begin
        n_cmp++; n_bad++;
        $display("FAIL arb_overlap: got both ready expected one");
      end
      if (m0_ready || m1_ready) begin
        exp_p = k[0];
        chk($sformatf("arb_port%0d", k), {31'd0, m1_ready}, {31'd0, exp_p});
        chk($sformatf("arb_gnt%0d", k), {31'd0, gnt_id}, {31'd0, exp_p});
        k++;
        if (k == 4) begin
          m0_req = 1'b0;
          m1_req = 1'b0;
        end
      end
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    chk("arb_count", k, 4);
    repeat (2) @(negedge clk);
    chk("arb_mem0", mem[20], 32'h11111111);
    chk("arb_mem1", mem[21], 32'h22222222);
    chk("arb_idle", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Arbitrates the single-port data-memory block RAM between two requesters.
- Port 0 is the CPU MEM stage; port 1 is the debug/loader bridge.
- Each access is sequenced through a small FSM. The block generates byte write-enables and lane-replicated write data, and returns load data extracted and sign/zero-extended to the requester.
- Sits between the requesters and the DM IP core: 13-bit word address, 4-bit wea, 1-cycle read latency.

Parameters:
- AW, 15, requester byte-address width. RAM word address is AW-2 = 13 bits.
- RESET_LAST, 1, value of the last-granted pointer after reset. With 1, port 0 wins the first tie.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- m0_req  in  1  port-0 request; held with its fields stable until m0_ready
- m0_we  in  1  1 = store, 0 = load
- m0_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- m0_sext  in  1  sign-extend load (byte/half only)
- m0_addr  in  AW  byte address
- m0_wdata  in  32  store data, right-aligned
- m0_ready  out  1  one-cycle completion pulse
- m0_rdata  out  32  load result, valid while m0_ready
- m0_err  out  1  misaligned/illegal flag, valid while m0_ready
- m1_req, m1_we, m1_size, m1_sext, m1_addr, m1_wdata, m1_ready, m1_rdata, m1_err  same as port 0, for port 1
- ram_wea  out  4  byte write enables to the RAM
- ram_addr  out  13  word address to the RAM
- ram_din  out  32  write data to the RAM
- ram_dout  in  32  RAM read data, valid the cycle after the address is presented
- busy  out  1  FSM not in IDLE
- gnt_id  out  1  port currently being served

Behaviour:
- Reset (reset=0, asynchronous) forces state IDLE and the last-granted pointer to RESET_LAST.
  - All outputs go to 0: ready, rdata, err, ram_wea, ram_addr, ram_din, busy, gnt_id.
  - Reset mid-access abandons the transaction with no ready pulse. ram_wea drops immediately.
- States are IDLE, ACCESS, WAIT and RESP.
- IDLE:
  - With no requests, stay in IDLE.
  - With one request, grant it.
  - With both requesting, grant the port not equal to the last-granted pointer.
  - On grant, latch we, size, sext, addr and wdata, set gnt_id, update the pointer, and go to ACCESS.
- ACCESS (1 cycle):
  - ram_addr = addr[AW-1:2].
  - Store: ram_wea is asserted per the enable rules below.
  - Load: ram_wea = 0.
  - Next state: store -> RESP, load -> WAIT, error -> RESP.
- WAIT (loads only):
  - Capture the formatted ram_dout into the granted port's rdata register.
  - Go to RESP.
- RESP:
  - Granted port's ready = 1 for exactly one cycle, with err and rdata valid. ram_wea = 0.
  - Go to IDLE. A req still high in the next IDLE cycle is a new request.
- Latency, counted from the req-sampling edge to the ready pulse: store = 2 cycles, load = 3 cycles, error = 2 cycles.
- Store byte enables:
  - word: wea = 1111.
  - half: wea = 0011 for addr[1] = 0, 1100 for addr[1] = 1.
  - byte: wea = 0001 << addr[1:0].
- Store data lanes:
  - byte: ram_din = {4{wdata[7:0]}}.
  - half: ram_din = {2{wdata[15:0]}}.
  - word: ram_din = wdata.
- Load formatting:
  - byte: select lane addr[1:0].
  - half: select lane addr[1].
  - Upper bits are filled with the sign bit if sext = 1, else zeros. Word loads ignore sext.
- Errors:
  - Conditions: half with addr[0] = 1, word with addr[1:0] != 0, or size = 3.
  - Response: no RAM write (wea = 0), err = 1, rdata = 0.
- The non-granted port's ready stays 0. Its rdata and err registers hold their previous values.
- Requests arriving while busy wait; nothing is queued beyond the level-held req.
- Fairness: under continuous contention, grants alternate strictly 0, 1, 0, 1, ...

Test Plan:
- Reset, then m0 stores word 0xDEADBEEF to addr 0x0010 -> ACCESS shows ram_addr = 4, wea = 1111, ram_din = 0xDEADBEEF; m0_ready is high 2 cycles after the req edge with err = 0.
- m0 stores byte 0x5A to addr 0x0013, then loads byte at 0x0013 with sext = 1 -> store uses wea = 1000, ram_din = 0x5A5A5A5A; load returns 0x0000005A. After storing byte 0x80 and loading with sext = 1 -> 0xFFFFFF80; with sext = 0 -> 0x00000080. Load ready comes 3 cycles after the req edge.
- Half store 0x1234 at addr 0x0022, then word load at 0x0020 -> wea = 1100; load returns 0x1234xxxx, where xxxx is the unchanged low half.
- m0 and m1 both hold req for 4 back-to-back transactions -> gnt_id sequence is 0, 1, 0, 1; no ready pulse overlaps; the waiting port is never starved.
- Word load at addr 0x0002 and access with size = 3 -> no wea asserted, err = 1, rdata = 0, ready 2 cycles after the req edge.
- reset asserted during WAIT of an m1 load -> busy, ram_wea and ready are 0 immediately with no ready pulse; after release, port 0 wins the first tie.
